// File: rtl/mrx_packer_pkg.sv
// Shared constants and helpers for the mrx frame packer.
package mrx_packer_pkg;

  localparam int ERR_W = 16;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mrx_packer.sv
// Packs IO beats into PW-wide packets (emode) or passes one beat per packet (raw).
// Optional short-frame counter enabled by defining MRX_PACKER_ERRCNT_EN.
module mrx_packer
  import mrx_packer_pkg::*;
#(
  parameter int IOW = 64,
  parameter int PW  = 104
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              emode,
  input  logic              access_in,
  input  logic [IOW/8-1:0]  valid_in,
  input  logic [IOW-1:0]    packet_in,
  output logic              wait_out,
  output logic              access_out,
  output logic [PW-1:0]     packet_out,
  input  logic              wait_in
`ifdef MRX_PACKER_ERRCNT_EN
  ,
  input  logic              err_clear,
  output logic [ERR_W-1:0]  err_count
`endif
);

  localparam int NB = ceil_div(PW, IOW);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  logic [CW-1:0] cnt;
  logic [PW-1:0] frame_buf;
  logic [PW-1:0] frame_p0;
  logic [PW-1:0] raw_p0;
  logic          accept;
  logic          last_beat;
  logic          emit;

  assign wait_out  = access_out & wait_in;
  assign accept    = access_in & ~wait_out;
  assign last_beat = (cnt == LAST) | ~(&valid_in);
  assign emit      = accept & (~emode | last_beat);

  // Stage p0: merge the incoming beat into its slot; bits past PW are dropped.
  always_comb begin
    frame_p0 = frame_buf;
    raw_p0   = '0;
    for (int i = 0; i < PW; i++) begin
      if (i / IOW == int'(cnt)) frame_p0[i] = packet_in[i % IOW];
      if (i < IOW)              raw_p0[i]   = packet_in[i % IOW];
    end
  end

  // Stage p1: frame state and output register. The buffer is cleared on every
  // completion or discard, so unwritten slots of the next frame read as zero.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt        <= '0;
      frame_buf  <= '0;
      access_out <= 1'b0;
      packet_out <= '0;
    end else begin
      if (!emode) begin
        cnt       <= '0;
        frame_buf <= '0;
      end else if (accept) begin
        if (last_beat) begin
          cnt       <= '0;
          frame_buf <= '0;
        end else begin
          cnt       <= cnt + 1'b1;
          frame_buf <= frame_p0;
        end
      end

      if (emit) begin
        access_out <= 1'b1;
        packet_out <= emode ? frame_p0 : raw_p0;
      end else if (!wait_in) begin
        access_out <= 1'b0;
      end
    end
  end

`ifdef MRX_PACKER_ERRCNT_EN
  logic short_frame;

  assign short_frame = accept & emode & last_beat & (cnt != LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_count <= '0;
    end else if (err_clear) begin
      err_count <= '0;
    end else if (short_frame && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mrx_packer.sv
// Scoreboard bench for mrx_packer: random and directed beats against a frame-level model.
module tb_mrx_packer;

  localparam int IOW = 64;
  localparam int PW  = 104;
  localparam int NB  = 2;
  localparam int VW  = IOW / 8;

  logic            clk = 1'b0;
  logic            nreset;
  logic            emode;
  logic            access_in;
  logic [VW-1:0]   valid_in;
  logic [IOW-1:0]  packet_in;
  logic            wait_out;
  logic            access_out;
  logic [PW-1:0]   packet_out;
  logic            wait_in;
`ifdef MRX_PACKER_ERRCNT_EN
  logic            err_clear;
  logic [15:0]     err_count;
`endif

  int checks = 0;
  int errors = 0;

  mrx_packer #(.IOW(IOW), .PW(PW)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .emode      (emode),
    .access_in  (access_in),
    .valid_in   (valid_in),
    .packet_in  (packet_in),
    .wait_out   (wait_out),
    .access_out (access_out),
    .packet_out (packet_out),
    .wait_in    (wait_in)
`ifdef MRX_PACKER_ERRCNT_EN
    ,
    .err_clear  (err_clear),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: beats of the current frame are kept as a list and the
  // packet is their concatenation, slot k at bit k*IOW.
  logic [IOW-1:0]    frames[$];
  logic [PW-1:0]     expq[$];
  bit                m_valid;
  int                m_err;
  bit                m_acc;
  bit                m_emit;
  logic [NB*IOW-1:0] m_wide;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frames.delete();
      expq.delete();
      m_valid = 0;
      m_err   = 0;
    end else begin
      m_acc  = access_in && !(m_valid && wait_in);
      m_emit = 0;
      if (m_acc && !emode) begin
        m_wide = '0;
        m_wide[IOW-1:0] = packet_in;
        expq.push_back(m_wide[PW-1:0]);
        m_emit = 1;
      end else if (m_acc) begin
        frames.push_back(packet_in);
        if (valid_in != '1 || frames.size() == NB) begin
          m_wide = '0;
          foreach (frames[k]) m_wide = m_wide | ((NB*IOW)'(frames[k]) << (k * IOW));
          expq.push_back(m_wide[PW-1:0]);
          m_emit = 1;
`ifdef MRX_PACKER_ERRCNT_EN
          if (frames.size() < NB && !err_clear && m_err < 65535) m_err++;
`endif
          frames.delete();
        end
      end
      if (!emode) frames.delete();
`ifdef MRX_PACKER_ERRCNT_EN
      if (err_clear) m_err = 0;
`endif
      if (m_emit) m_valid = 1;
      else if (!wait_in) m_valid = 0;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (nreset) begin
      chk("access_out", PW'(access_out), PW'(m_valid));
      chk("wait_out", PW'(wait_out), PW'(m_valid && wait_in));
      if (access_out) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got packet %h, expected none", packet_out);
        end else begin
          chk("packet_out", packet_out, expq[0]);
          if (!wait_in) void'(expq.pop_front());
        end
      end
`ifdef MRX_PACKER_ERRCNT_EN
      chk("err_count", PW'(err_count), PW'(m_err));
`endif
    end
  end

  task automatic drive(input logic em, input logic acc, input logic [VW-1:0] vm,
                       input logic [IOW-1:0] d, input logic wi);
    @(posedge clk);
    #1;
    emode     = em;
    access_in = acc;
    valid_in  = vm;
    packet_in = d;
    wait_in   = wi;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '1, '0, 1'b0);
  endtask

  initial begin
    logic [IOW-1:0] a, b, x, y, z;
    logic [VW-1:0]  vm;

    nreset    = 1'b0;
    emode     = 1'b1;
    access_in = 1'b0;
    valid_in  = '0;
    packet_in = '0;
    wait_in   = 1'b1;
`ifdef MRX_PACKER_ERRCNT_EN
    err_clear = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_access_out", PW'(access_out), '0);
    chk("rst_packet_out", packet_out, '0);
    chk("rst_wait_out", PW'(wait_out), '0);
    nreset = 1'b1;

    // Two-beat frame, second beat partially valid.
    a = 64'h1111_2222_3333_4444;
    b = 64'hAAAA_BBBB_CCCC_DDDD;
    drive(1, 1, 8'hFF, a, 0);
    drive(1, 1, 8'h1F, b, 0);
    idle();
    @(negedge clk);
    chk("two_beat_frame", packet_out, {40'hBB_CCCC_DDDD, a});

    // Short single-beat frame.
    drive(1, 1, 8'h0F, a, 0);
    idle();
    @(negedge clk);
    chk("short_frame", packet_out, {40'h0, a});
`ifdef MRX_PACKER_ERRCNT_EN
    chk("short_err_count", PW'(err_count), PW'(16'd1));
    @(posedge clk); #1 err_clear = 1'b1;
    @(posedge clk); #1 err_clear = 1'b0;
    @(negedge clk);
    chk("err_clear", PW'(err_count), '0);
`endif

    // Downstream backpressure blocks upstream beats.
    x = 64'h0123_4567_89AB_CDEF;
    y = 64'h5555_6666_7777_8888;
    z = 64'h9999_AAAA_BBBB_CCCC;
    drive(0, 1, 8'hFF, x, 1);
    drive(1, 1, 8'hFF, y, 1);
    @(negedge clk);
    chk("stall_wait_out", PW'(wait_out), PW'(1'b1));
    drive(1, 1, 8'hFF, y, 1);
    @(negedge clk);
    chk("stall_hold", packet_out, {40'h0, x});
    drive(1, 1, 8'hFF, y, 0);
    drive(1, 1, 8'hFF, z, 0);
    idle();
    @(negedge clk);
    chk("after_stall", packet_out, {z[39:0], y});

    // Raw mode, four back-to-back beats.
    for (int i = 0; i < 4; i++) drive(0, 1, 8'($urandom), {$urandom, $urandom}, 0);
    idle();

    // Partial frame discarded by leaving emode.
    drive(1, 1, 8'hFF, x, 0);
    drive(0, 0, 8'hFF, x, 0);
    drive(1, 1, 8'hFF, y, 0);
    drive(1, 1, 8'h03, z, 0);
    idle();
    @(negedge clk);
    chk("discard_partial", packet_out, {z[39:0], y});

    // Asynchronous reset mid-frame.
    drive(1, 1, 8'hFF, x, 0);
    idle();
    #2 nreset = 1'b0;
    #1;
    chk("async_rst_access", PW'(access_out), '0);
    chk("async_rst_packet", packet_out, '0);
    @(negedge clk);
    nreset = 1'b1;
    drive(1, 1, 8'hFF, y, 0);
    drive(1, 1, 8'hFF, z, 0);
    idle();
    @(negedge clk);
    chk("post_reset_frame", packet_out, {z[39:0], y});

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      vm = ($urandom_range(0, 9) < 6) ? '1 : VW'($urandom);
`ifdef MRX_PACKER_ERRCNT_EN
      err_clear = ($urandom_range(0, 49) == 0);
`endif
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, vm,
            {$urandom, $urandom}, $urandom_range(0, 9) < 3);
    end
`ifdef MRX_PACKER_ERRCNT_EN
    err_clear = 1'b0;
`endif
    repeat (4) idle();
    @(negedge clk);
    chk("scoreboard_drained", PW'(expq.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrx_packer.md
MRX_PACKER -- requirements
Module: mrx_packer

Interface
REQ-001 SHALL have parameter IOW, default 64, meaning IO beat width in bits (multiple of 8).
REQ-002 SHALL have parameter PW, default 104, meaning assembled packet width in bits.
REQ-003 SHALL derive localparam NB = ceil(PW/IOW), meaning beats per full frame (2 at defaults).
REQ-004 SHALL have port clk  input  1  single core clock; all logic on its rising edge.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port emode  input  1  1 = multi-beat frame assembly; 0 = raw mode, one beat per packet.
REQ-007 SHALL have port access_in  input  1  beat valid.
REQ-008 SHALL have port valid_in  input  IOW/8  byte-valid mask of the beat.
REQ-009 SHALL have port packet_in  input  IOW  beat data.
REQ-010 SHALL have port wait_out  output  1  pushback to upstream.
REQ-011 SHALL have port access_out  output  1  packet valid.
REQ-012 SHALL have port packet_out  output  PW  assembled packet.
REQ-013 SHALL have port wait_in  input  1  pushback from downstream.

Function
REQ-014 A beat SHALL be accepted when access_in=1 and wait_out=0; otherwise it is ignored.
REQ-015 wait_out SHALL equal access_out AND wait_in (combinational).
REQ-016 Beat counter cnt (0..NB-1) SHALL select the slot; an accepted beat writes bits [cnt*IOW +: IOW] of the frame buffer, truncated to PW.
REQ-017 In emode, a frame SHALL complete on an accepted beat whose valid_in is not all-ones, or whose cnt equals NB-1.
REQ-018 On completion, cnt SHALL return to 0; otherwise cnt increments by 1.
REQ-019 Slots not written in a completed frame SHALL read as zero in packet_out; stale data never leaks.
REQ-020 access_out SHALL assert the cycle after the completing beat is accepted, with packet_out loaded in the same edge.
REQ-021 While access_out=1 and wait_in=1, access_out and packet_out SHALL hold.
REQ-022 When access_out=1 and wait_in=0, the packet is consumed; a frame completing in that same cycle SHALL load without a bubble, else access_out drops to 0.
REQ-023 In raw mode, each accepted beat SHALL produce one packet: packet_out = packet_in zero-extended or truncated to PW; valid_in ignored.
REQ-024 emode deasserting with cnt!=0 SHALL discard the partial frame and clear cnt and buffer the next cycle; no packet emitted for it.
REQ-025 A short frame SHALL be a completed emode frame with cnt<NB-1 at completion; it is still emitted.

Reset
REQ-026 On nreset low, asynchronously: access_out=0, packet_out=0, cnt=0, frame buffer=0, error counter=0.
REQ-027 Reset mid-frame SHALL drop the partial frame; first beat after release is slot 0.

Configuration
REQ-028 Macro MRX_PACKER_ERRCNT_EN defined SHALL add ports err_clear (input, 1) and err_count (output, 16): saturating count of short frames, cleared synchronously by err_clear (clear wins over simultaneous increment).
REQ-029 Without MRX_PACKER_ERRCNT_EN, those ports and the counter SHALL not exist; all other behaviour is identical.

Structure
REQ-030 The NB ceiling-divide function and the err_count width constant SHALL live in the shared mrx package; NB itself stays a local parameter.
REQ-031 No sub-module; frame buffer, counter and output register are inline.

Verification (PW=104, IOW=64)
REQ-032 emode, beat A=0x1111_2222_3333_4444 valid 0xFF, then beat B=0xAAAA_BBBB_CCCC_DDDD valid 0x1F -> next cycle access_out=1, packet_out={B[39:0],A}.
REQ-033 emode, single beat A valid 0x0F -> packet_out = {40'h0, A}; with macro, err_count=1; err_clear -> 0.
REQ-034 wait_in=1 while access_out=1, upstream drives two beats -> wait_out=1, beats not accepted, packet_out unchanged; wait_in=0 -> beats accepted, next packet follows.
REQ-035 emode=0, four consecutive beats -> four packets on consecutive cycles, each one cycle after its beat, upper 40 bits zero.
REQ-036 emode, one full beat accepted, then emode=0 for one cycle, then emode=1 and a 2-beat frame -> only the new frame is emitted, correct slots.
REQ-037 nreset pulsed low after first beat of a frame -> all outputs 0 immediately; subsequent 2-beat frame assembles correctly.
